coproc_host_driver: RTL

- Host-side initiator for the bit-matrix systolic coprocessor.
- Drives the coprocessor's byte input (ui_in) and control lines (sayhi/readout/usexor), and samples its byte output (uo_out).
- Turns operand-pair requests (valid/ready) into the coprocessor's alternating in1/in2 byte protocol, then sequences flush, readout and result-row capture.
- Shares clk and reset with the coprocessor instance; the driver's reset must coincide with the coprocessor's.

---
 rtl/coproc_host_driver.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/coproc_host_driver.sv
// Host-side initiator for the bit-matrix systolic coprocessor: operand streaming, flush, row readout.
// Define COPROC_DRV_HELLO_CHECK_EN to add the sayhi greeting self-check (hello_req/done/pass).

module coproc_host_driver #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       cfg_xor,
    input  logic       rd_req,
    output logic       rd_ack,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [2:0] res_row,
    output logic       res_last,
    output logic       busy,
    output logic [7:0] cp_ui_in,
    output logic       cp_sayhi,
    output logic       cp_readout,
    output logic       cp_usexor,
`ifdef COPROC_DRV_HELLO_CHECK_EN
    input  logic       hello_req,
    output logic       hello_done,
    output logic       hello_pass,
`endif
    input  logic [7:0] cp_uo_out
);

    localparam logic [1:0] ST_STREAM = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
`ifdef COPROC_DRV_HELLO_CHECK_EN
    localparam logic [1:0] ST_HELLO  = 2'd3;
`endif

    localparam logic [7:0] FLUSH_LAST = 8'(2 * N - 1);
    localparam logic [7:0] READ_LAST  = 8'(N);

    logic [1:0] state_q, state_d;
    logic       ph_q, ph_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_b_q, pend_b_d;
    logic [7:0] b_hold_q, b_hold_d;
    logic       xor_q, xor_d;
    logic       arm_q, arm_d;
    logic [7:0] ui_q, ui_d;
    logic       rdo_q, rdo_d;
    logic       rv_q, rv_d;
    logic [7:0] rdat_q, rdat_d;
    logic [2:0] rrow_q, rrow_d;
    logic       rlast_q, rlast_d;

    logic       stream_b;
    logic       op_acc;

`ifdef COPROC_DRV_HELLO_CHECK_EN
    logic       hi_q, hi_d;
    logic       hok_q, hok_d;
    logic       hdone_q, hdone_d;
    logic       hpass_q, hpass_d;
    logic       hello_acc;
    logic       hmatch;

    function automatic logic [7:0] hello_byte(input logic [3:0] k);
        logic [7:0] b;
        case (k)
            4'd3:    b = 8'h49;
            4'd4:    b = 8'h20;
            4'd5:    b = 8'h61;
            4'd6:    b = 8'h6D;
            4'd7:    b = 8'h20;
            4'd8:    b = 8'h50;
            4'd9:    b = 8'h72;
            4'd10:   b = 8'h6F;
            4'd11:   b = 8'h62;
            4'd12:   b = 8'h6F;
            4'd13:   b = 8'h74;
            4'd14:   b = 8'h21;
            default: b = 8'h00;
        endcase
        return b;
    endfunction
`endif

    // Handshakes only open on the in2 slot so each accepted pair starts on phase A.
    assign stream_b = !reset && (state_q == ST_STREAM) && ph_q;
    assign rd_ack   = stream_b && rd_req;
    assign op_ready = stream_b && !rd_req;
    assign op_acc   = op_valid && op_ready;

`ifdef COPROC_DRV_HELLO_CHECK_EN
    assign hello_acc = stream_b && !rd_req && !op_acc && hello_req;
    assign hmatch    = (cp_uo_out == hello_byte(cnt_q[3:0]));
`endif

    always_comb begin
        state_d  = state_q;
        ph_d     = (state_q == ST_READ) ? 1'b0 : ~ph_q;
        cnt_d    = cnt_q;
        pend_b_d = 1'b0;
        b_hold_d = b_hold_q;
        xor_d    = xor_q;
        arm_d    = arm_q;
        ui_d     = 8'h00;
        rdo_d    = 1'b0;
        rv_d     = 1'b0;
        rdat_d   = 8'h00;
        rrow_d   = 3'd0;
        rlast_d  = 1'b0;
`ifdef COPROC_DRV_HELLO_CHECK_EN
        hi_d     = 1'b0;
        hok_d    = hok_q;
        hdone_d  = 1'b0;
        hpass_d  = 1'b0;
`endif
        unique case (state_q)
            ST_STREAM: begin
                if (pend_b_q) begin
                    ui_d = b_hold_q;
                end
                if (op_acc) begin
                    ui_d     = op_a;
                    b_hold_d = op_b;
                    pend_b_d = 1'b1;
                    if (arm_q) begin
                        xor_d = cfg_xor;
                        arm_d = 1'b0;
                    end
                end
                if (rd_ack) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 8'd0;
                end
`ifdef COPROC_DRV_HELLO_CHECK_EN
                if (hello_acc) begin
                    state_d = ST_HELLO;
                    cnt_d   = 8'd0;
                    hi_d    = 1'b1;
                    hok_d   = 1'b1;
                end
`endif
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_READ;
                    cnt_d   = 8'd0;
                    rdo_d   = 1'b1;
                end
            end
            ST_READ: begin
                rdo_d = (cnt_q != READ_LAST);
                cnt_d = cnt_q + 8'd1;
                // Slot r = 0 only primes the output mux; rows arrive from r = 1.
                if (cnt_q != 8'd0) begin
                    rv_d    = 1'b1;
                    rdat_d  = cp_uo_out;
                    rrow_d  = 3'(N - int'(cnt_q));
                    rlast_d = (cnt_q == READ_LAST);
                end
                if (cnt_q == READ_LAST) begin
                    state_d = ST_STREAM;
                    cnt_d   = 8'd0;
                    arm_d   = 1'b1;
                end
            end
`ifdef COPROC_DRV_HELLO_CHECK_EN
            ST_HELLO: begin
                cnt_d = cnt_q + 8'd1;
                hok_d = hok_q && hmatch;
                hi_d  = (cnt_q != 8'd15);
                if (cnt_q == 8'd15) begin
                    state_d = ST_STREAM;
                    cnt_d   = 8'd0;
                    hdone_d = 1'b1;
                    hpass_d = hok_q && hmatch;
                end
            end
`endif
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_STREAM;
            ph_q     <= 1'b0;
            cnt_q    <= 8'd0;
            pend_b_q <= 1'b0;
            b_hold_q <= 8'h00;
            xor_q    <= 1'b0;
            arm_q    <= 1'b1;
            ui_q     <= 8'h00;
            rdo_q    <= 1'b0;
            rv_q     <= 1'b0;
            rdat_q   <= 8'h00;
            rrow_q   <= 3'd0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            pend_b_q <= pend_b_d;
            b_hold_q <= b_hold_d;
            xor_q    <= xor_d;
            arm_q    <= arm_d;
            ui_q     <= ui_d;
            rdo_q    <= rdo_d;
            rv_q     <= rv_d;
            rdat_q   <= rdat_d;
            rrow_q   <= rrow_d;
            rlast_q  <= rlast_d;
        end
    end

`ifdef COPROC_DRV_HELLO_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= 1'b0;
            hok_q   <= 1'b0;
            hdone_q <= 1'b0;
            hpass_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            hok_q   <= hok_d;
            hdone_q <= hdone_d;
            hpass_q <= hpass_d;
        end
    end

    assign cp_sayhi   = hi_q;
    assign hello_done = hdone_q;
    assign hello_pass = hpass_q;
`else
    assign cp_sayhi   = 1'b0;
`endif

    assign busy       = (state_q == ST_FLUSH) || (state_q == ST_READ);
    assign cp_ui_in   = ui_q;
    assign cp_readout = rdo_q;
    assign cp_usexor  = xor_q;
    assign res_valid  = rv_q;
    assign res_data   = rdat_q;
    assign res_row    = rrow_q;
    assign res_last   = rlast_q;

endmodule
